// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential fetch-address generation, a credit-limited
// in-order request/response channel, and a small {pc, word} queue feeding decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, redirect_tgt, rsp_pc;
  logic [CW-1:0] outstanding, discard, count, inflight_nxt;
  logic [CW:0]   credits_used;
  logic [PW-1:0] rd_ptr, wr_ptr;
  entry_t        q [DEPTH];
  logic          req_fire, rsp_ok, enq, deq;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign credits_used = {1'b0, count} + {1'b0, outstanding};
  assign req_fire     = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign rsp_ok       = imem_rsp_valid & (outstanding != '0);
  assign enq          = rsp_ok & ~redirect & (state == RUN);
  assign deq          = inst_valid & inst_ready & ~redirect;
  assign inflight_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);
  // Responses return in order, so the oldest unanswered request is outstanding words back.
  assign rsp_pc       = fetch_pc - (32'(outstanding) << 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect)
      state_nxt = (inflight_nxt != '0) ? FLUSH : RUN;
    else if (state == FLUSH && (discard == '0 || (rsp_ok && discard == CW'(1))))
      state_nxt = RUN;
  end

  always_comb begin
    imem_req_valid = (state == RUN) && (credits_used < (CW+1)'(DEPTH));
    inst_valid     = (count != '0);
  end

  assign imem_req_addr = fetch_pc;
  assign inst          = q[rd_ptr].word;
  assign inst_pc       = q[rd_ptr].pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      outstanding <= inflight_nxt;
      if (redirect) begin
        // Everything in flight, including this cycle's accepted request, becomes stale.
        fetch_pc <= redirect_tgt;
        discard  <= inflight_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (state == FLUSH && rsp_ok && discard != '0) discard <= discard - CW'(1);
        if (enq) begin
          q[wr_ptr] <= '{pc: rsp_pc, word: imem_rsp_data};
          wr_ptr    <= wr_ptr + PW'(1);
        end
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order variable-latency memory plus a
// queue-level reference model of the fetch stream, with directed scenario tasks.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, p_ready = 100, pi_ready = 100;
  bit spurious = 0;
  bit do_redir = 0, redir_on_collide = 0, redir_fired = 0;
  logic [31:0] redir_tgt = 32'h0;
  int redir_cyc = 0, redir_out0 = 0, redir_pops = 0;

  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due = 0;

  ent_t        mq[$];
  int          m_out = 0, m_disc = 0;
  logic [31:0] m_fetch = RPC;

  logic [31:0] pop_pc[$], pop_word[$], fire_addr[$];
  int          fire_cyc[$], rsp_cyc[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h0040_0000) >> 2);
  endfunction

  // One clock: drive memory/decode/redirect at negedge, compare against the model,
  // then advance memory and model across the rising edge.
  task automatic cycle();
    bit fire, rsp, mem_rsp, pop, redir, rsp_ok, exp_rv, exp_iv;
    int lat;
    logic [31:0] ipc, iw, raddr, rpc;
    @(negedge clk);
    mem_rsp = (mem_due.size() != 0) && (mem_due[0] <= cyc);
    imem_rsp_valid = mem_rsp;
    imem_rsp_data  = mem_rsp ? word_of(mem_addr[0]) : 32'h0;
    if (!mem_rsp && spurious && mem_addr.size() == 0 && $urandom_range(1, 0) == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = ($urandom_range(99, 0) < p_ready);
    inst_ready     = ($urandom_range(99, 0) < pi_ready);
    redir = do_redir || (redir_on_collide && inst_valid && imem_rsp_valid && imem_req_valid && imem_req_ready);
    redirect    = redir;
    redirect_pc = redir_tgt;
    #1;
    exp_rv = (m_disc == 0) && ((mq.size() + m_out) < DEPTH);
    vectors++;
    if (imem_req_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL req_valid @%0d: got %b want %b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      vectors++;
      if (imem_req_addr !== m_fetch) begin
        miscompares++;
        $display("FAIL req_addr @%0d: got %h want %h", cyc, imem_req_addr, m_fetch);
      end
    end
    exp_iv = (mq.size() != 0);
    vectors++;
    if (inst_valid !== exp_iv) begin
      miscompares++;
      $display("FAIL inst_valid @%0d: got %b want %b", cyc, inst_valid, exp_iv);
    end
    if (exp_iv) begin
      vectors++;
      if (inst !== mq[0].word || inst_pc !== mq[0].pc) begin
        miscompares++;
        $display("FAIL head @%0d: got %h/%h want %h/%h", cyc, inst_pc, inst, mq[0].pc, mq[0].word);
      end
    end
    fire  = imem_req_valid & imem_req_ready;
    rsp   = imem_rsp_valid;
    pop   = inst_valid & inst_ready & !redir;
    raddr = imem_req_addr;
    ipc   = inst_pc;
    iw    = inst;
    @(posedge clk);
    rpc = 32'h0;
    if (mem_rsp) begin
      rpc = mem_addr.pop_front();
      void'(mem_due.pop_front());
      rsp_cyc.push_back(cyc);
    end
    if (fire) begin
      lat = int'($urandom_range(lat_max, lat_min));
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
      mem_addr.push_back(raddr);
      mem_due.push_back(last_due);
      fire_addr.push_back(raddr);
      fire_cyc.push_back(cyc);
    end
    if (pop) begin
      pop_pc.push_back(ipc);
      pop_word.push_back(iw);
    end
    rsp_ok = rsp && (m_out > 0);
    if (redir) begin
      redir_fired = 1;
      redir_cyc   = cyc;
      redir_out0  = m_out;
      redir_pops  = pop_pc.size();
      mq.delete();
      m_out   = m_out + int'(fire) - int'(rsp_ok);
      m_disc  = m_out;
      m_fetch = redir_tgt & 32'hFFFF_FFFC;
      do_redir = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rsp_ok) begin
        if (m_disc > 0) m_disc--;
        else mq.push_back('{rpc, word_of(rpc)});
        m_out--;
      end
      if (fire) begin
        m_out++;
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
    mq.delete(); mem_addr.delete(); mem_due.delete();
    last_due = 0; m_out = 0; m_disc = 0; m_fetch = RPC;
    pop_pc.delete(); pop_word.delete(); fire_addr.delete(); fire_cyc.delete(); rsp_cyc.delete();
    do_redir = 0; redir_on_collide = 0; redir_fired = 0; spurious = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); end
    vectors++;
    if (imem_req_addr !== RPC) begin miscompares++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RPC); end
    vectors++;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    vectors++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++; $display("FAIL reset_inst: got %h/%h want 0/0", inst_pc, inst);
    end
    @(negedge clk);
    reset = 1'b1;
    // Stray responses with nothing outstanding must not reach decode.
    spurious = 1; p_ready = 0; pi_ready = 100;
    repeat (8) cycle();
    spurious = 0;
    #1;
    vectors++;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL spurious_rsp: inst_valid got %b want 0", inst_valid); end
    vectors++;
    if (imem_req_addr !== RPC) begin miscompares++; $display("FAIL spurious_pc: got %h want %h", imem_req_addr, RPC); end
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1; p_ready = 100; pi_ready = 100;
    repeat (12) cycle();
    vectors++;
    if (pop_pc.size() !== 10) begin miscompares++; $display("FAIL stream_rate: got %0d pops want 10", pop_pc.size()); end
    for (int i = 0; i < 8 && i < pop_pc.size(); i++) begin
      vectors++;
      if (pop_word[i] !== 32'hA0 + i || pop_pc[i] !== RPC + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_%0d: got %h/%h want %h/%h", i, pop_pc[i], pop_word[i], RPC + 32'(4 * i), 32'hA0 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat_min = 1; lat_max = 1; p_ready = 100; pi_ready = 0;
    repeat (10) cycle();
    #1;
    vectors++;
    if (fire_addr.size() !== DEPTH) begin miscompares++; $display("FAIL bp_requests: got %0d want %0d", fire_addr.size(), DEPTH); end
    vectors++;
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      miscompares++; $display("FAIL bp_head: got %b/%h want 1/%h", inst_valid, inst_pc, RPC);
    end
    pi_ready = 100;
    repeat (8) cycle();
    vectors++;
    if (pop_pc.size() < 5) begin
      miscompares++; $display("FAIL bp_drain: got %0d pops want >=5", pop_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (pop_pc[i] !== RPC + 32'(4 * i)) begin
          miscompares++; $display("FAIL bp_pop_%0d: got %h want %h", i, pop_pc[i], RPC + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    lat_min = 3; lat_max = 3; p_ready = 100; pi_ready = 100;
    repeat (2) cycle();
    p_ready = 0; do_redir = 1; redir_tgt = 32'h0000_0103;
    cycle();
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_entry: got req %b inst %b want 0/0", imem_req_valid, inst_valid);
    end
    p_ready = 100;
    repeat (10) cycle();
    vectors++;
    if (fire_addr.size() < 3 || rsp_cyc.size() < 2) begin
      miscompares++; $display("FAIL flush_resume: got %0d requests want >=3", fire_addr.size());
    end else begin
      vectors++;
      if (fire_addr[2] !== 32'h0000_0100) begin
        miscompares++; $display("FAIL flush_addr: got %h want 00000100", fire_addr[2]);
      end
      vectors++;
      if (fire_cyc[2] !== rsp_cyc[1] + 1) begin
        miscompares++; $display("FAIL flush_timing: got cycle %0d want %0d", fire_cyc[2], rsp_cyc[1] + 1);
      end
    end
    vectors++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0000_0100) begin
      miscompares++; $display("FAIL flush_first_pc: got %0d pops, first %h want 00000100", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    int k, stale;
    do_reset();
    lat_min = 2; lat_max = 2; p_ready = 100; pi_ready = 100;
    repeat (6) cycle();
    redir_on_collide = 1; redir_tgt = 32'h0000_2000;
    for (int i = 0; i < 20 && !redir_fired; i++) cycle();
    redir_on_collide = 0;
    vectors++;
    if (!redir_fired) begin
      miscompares++; $display("FAIL collide_timeout: got no collision within 20 cycles want one");
      return;
    end
    #1;
    vectors++;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL collide_cleared: inst_valid got %b want 0", inst_valid); end
    repeat (12) cycle();
    k = -1;
    foreach (fire_cyc[i]) if (k < 0 && fire_cyc[i] > redir_cyc) k = i;
    vectors++;
    if (k < 0) begin
      miscompares++; $display("FAIL collide_resume: got no request after redirect want one");
    end else begin
      stale = 0;
      foreach (rsp_cyc[i]) if (rsp_cyc[i] > redir_cyc && rsp_cyc[i] < fire_cyc[k]) stale++;
      vectors++;
      if (stale !== redir_out0 + 1 - 1) begin
        miscompares++; $display("FAIL collide_discard: got %0d dropped want %0d", stale, redir_out0);
      end
      vectors++;
      if (fire_addr[k] !== 32'h0000_2000) begin
        miscompares++; $display("FAIL collide_addr: got %h want 00002000", fire_addr[k]);
      end
    end
    vectors++;
    if (pop_pc.size() <= redir_pops || pop_pc[redir_pops] !== 32'h0000_2000) begin
      miscompares++; $display("FAIL collide_first_pc: got %0d pops after redirect want first pc 00002000", pop_pc.size() - redir_pops);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    lat_min = 1; lat_max = 1; p_ready = 100; pi_ready = 100;
    do_redir = 1; redir_tgt = 32'hFFFF_FFF8;
    repeat (10) cycle();
    vectors++;
    if (pop_pc.size() < 3) begin
      miscompares++; $display("FAIL wrap_count: got %0d pops want >=3", pop_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (pop_pc[i] !== exp_pc[i] || pop_word[i] !== word_of(exp_pc[i])) begin
          miscompares++; $display("FAIL wrap_%0d: got %h/%h want %h/%h", i, pop_pc[i], pop_word[i], exp_pc[i], word_of(exp_pc[i]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 2; lat_max = 2; p_ready = 100; pi_ready = 50;
    repeat (6) cycle();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC || inst !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got iv %b rv %b addr %h inst %h want 0/1/%h/0", inst_valid, imem_req_valid, imem_req_addr, inst, RPC);
    end
    do_reset();
    repeat (8) cycle();
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4; p_ready = 75; pi_ready = 65;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) begin
        do_redir  = 1;
        redir_tgt = $urandom;
      end
      cycle();
    end
    vectors++;
    if (pop_pc.size() < 300) begin
      miscompares++; $display("FAIL random_progress: got %0d pops want >=300", pop_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
